// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
//   uart_rx_state_t : receiver FSM states
//   IMG_MAGIC0/1    : two-byte image-start marker (0x55 then 0xAA)
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;
  localparam logic [7:0] IMG_MAGIC0 = 8'h55;
  localparam logic [7:0] IMG_MAGIC1 = 8'hAA;
endpackage

// File: rtl/uart_rx_core.sv
// 8N1 deserialiser: 2-flop synchroniser, bit timer, receive FSM.
// Optional macro UART_RX_MAJORITY_EN: each sample point becomes a 2-of-3
// vote over rxs at expiry-1/0/+1, acted on one cycle after expiry.
// Ports:
//   clk, rst         : clock, synchronous active-low reset
//   i_rx             : raw pad input, idle high
//   o_byte           : assembled byte (valid while o_valid=1)
//   o_valid          : one-cycle pulse, good stop bit
//   o_ferr           : one-cycle pulse, stop bit sampled low
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ  = 27_000_000,
  parameter int BAUD      = 115200,
  parameter int TIM_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_rx,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_ferr
);
  localparam int BIT_CYC = CLOCK_HZ / BAUD;
`ifdef UART_RX_MAJORITY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif
  // Timer counts load value down to 0; expiry is the cycle it reads 0.
  // With the vote enabled the action lands one cycle late, so the bit
  // reload is one shorter to keep sample points a full bit apart.
  localparam logic [TIM_WIDTH-1:0] HALF_LD = TIM_WIDTH'(BIT_CYC / 2 - 1);
  localparam logic [TIM_WIDTH-1:0] BIT_LD  = TIM_WIDTH'(BIT_CYC - 1 - DLY);

  uart_rx_state_t       r_state, w_state_n;
  logic                 r_s1, r_s2, r_prev;
  logic [TIM_WIDTH-1:0] r_tim;
  logic [2:0]           r_idx;
  logic [7:0]           r_shift;
  logic                 w_exp, w_tick, w_bit;
  logic                 w_load_half, w_load_bit, w_shift;

`ifdef UART_RX_MAJORITY_EN
  logic r_prev2, r_exp_d;
  // r_exp_d blocks a second expiry while the timer waits at 0 for the tick
  assign w_exp  = (r_state != IDLE) && (r_tim == '0) && !r_exp_d;
  assign w_tick = r_exp_d;
  assign w_bit  = (r_s2 & r_prev) | (r_s2 & r_prev2) | (r_prev & r_prev2);
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prev2 <= 1'b1;
      r_exp_d <= 1'b0;
    end else begin
      r_prev2 <= r_prev;
      r_exp_d <= w_exp;
    end
  end
`else
  assign w_exp  = (r_state != IDLE) && (r_tim == '0);
  assign w_tick = w_exp;
  assign w_bit  = r_s2;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= IDLE;
      r_tim   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_s1    <= i_rx;
      r_s2    <= r_s1;
      r_prev  <= r_s2;
      r_state <= w_state_n;
      if (w_load_half)     r_tim <= HALF_LD;
      else if (w_load_bit) r_tim <= BIT_LD;
      else if (r_tim != '0) r_tim <= r_tim - 1'b1;
      if (r_state == START) r_idx <= '0;
      else if (w_shift)     r_idx <= r_idx + 3'd1;
      if (w_shift) r_shift <= {w_bit, r_shift[7:1]};
    end
  end

  always_comb begin
    w_state_n   = r_state;
    w_load_half = 1'b0;
    w_load_bit  = 1'b0;
    w_shift     = 1'b0;
    o_valid     = 1'b0;
    o_ferr      = 1'b0;
    case (r_state)
      IDLE: if (r_prev && !r_s2) begin
        w_state_n   = START;
        w_load_half = 1'b1;
      end
      START: if (w_tick) begin
        if (w_bit) w_state_n = IDLE;   // false start
        else begin
          w_state_n  = DATA;
          w_load_bit = 1'b1;
        end
      end
      DATA: if (w_tick) begin
        w_shift    = 1'b1;
        w_load_bit = 1'b1;
        if (r_idx == 3'd7) w_state_n = STOP;
      end
      STOP: if (w_tick) begin
        w_state_n = IDLE;
        o_valid   = w_bit;
        o_ferr    = !w_bit;
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign o_byte = r_shift;
endmodule

// File: rtl/uart_rx_img.sv
// UART receive front end with image-start (0x55 0xAA) detection.
// Optional macro UART_RX_MAJORITY_EN (see uart_rx_core).
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   rx            : serial input, idle high
//   rx_data/full  : last byte and its waiting flag; rd clears rx_full
//   img_recv      : one-cycle pulse on marker completion
//   end_img_recv  : loader done, leave image mode
//   img_mode      : image transfer in progress
//   frame_err     : one-cycle pulse on bad stop bit
//   overrun       : sticky, byte arrived while rx_full=1 and rd=0
module uart_rx_img
  import uart_pkg::*;
#(
  parameter int CLOCK_HZ  = 27_000_000,
  parameter int BAUD      = 115200,
  parameter int TIM_WIDTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_full,
  input  logic       rd,
  output logic       img_recv,
  input  logic       end_img_recv,
  output logic       img_mode,
  output logic       frame_err,
  output logic       overrun
);
  logic [7:0] w_byte;
  logic       w_valid, w_ferr, w_marker, w_deliver;
  logic       r_prev55;

  uart_rx_core #(.CLOCK_HZ(CLOCK_HZ), .BAUD(BAUD), .TIM_WIDTH(TIM_WIDTH)) u_core (
    .clk(clk), .rst(rst), .i_rx(rx),
    .o_byte(w_byte), .o_valid(w_valid), .o_ferr(w_ferr)
  );

  // The marker's 0xAA is swallowed; everything else valid is delivered.
  assign w_marker  = w_valid && !img_mode && r_prev55 && (w_byte == IMG_MAGIC1);
  assign w_deliver = w_valid && !w_marker;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_data   <= '0;
      rx_full   <= 1'b0;
      img_recv  <= 1'b0;
      img_mode  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      r_prev55  <= 1'b0;
    end else begin
      frame_err <= w_ferr;
      img_recv  <= w_marker;
      // delivery wins over a same-cycle rd
      if (w_deliver) begin
        rx_data <= w_byte;
        rx_full <= 1'b1;
        if (rx_full && !rd) overrun <= 1'b1;
      end else if (rd) begin
        rx_full <= 1'b0;
      end
      if (end_img_recv && img_mode) begin
        img_mode <= 1'b0;
        r_prev55 <= 1'b0;
      end
      if (!img_mode) begin
        if (w_marker) begin
          img_mode <= 1'b1;
          r_prev55 <= 1'b0;
        end else if (w_valid) r_prev55 <= (w_byte == IMG_MAGIC0);
        else if (w_ferr)      r_prev55 <= 1'b0;
      end
    end
  end
endmodule

// File: doc/uart_rx_img.md
Name: uart_rx_img

Overview:
- UART receive front end with memory-image start detection.
- Sits directly upstream of the MCU image loader and peripheral register block, inside the UART mux, beside the TX path.
- Deserialises 8N1 frames from the pad, presents bytes with a full/read handshake, and detects the 0x55 0xAA image-start marker.
- Holds "image mode" until the loader signals completion.

Parameters:
- CLOCK_HZ, 27_000_000, system clock frequency in Hz.
- BAUD, 115200, line rate; bit period BIT_CYC = CLOCK_HZ/BAUD, truncated.
- TIM_WIDTH, 8, width of the bit-timing counter; must satisfy BIT_CYC < 2**TIM_WIDTH.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset.
- rx  input  1  asynchronous serial input, idle high.
- rx_data  output  8  last received byte.
- rx_full  output  1  a byte is waiting in rx_data.
- rd  input  1  consumer acknowledge; clears rx_full.
- img_recv  output  1  one-cycle pulse when the marker completes.
- end_img_recv  input  1  loader finished; leave image mode.
- img_mode  output  1  image transfer in progress.
- frame_err  output  1  one-cycle pulse on a bad stop bit.
- overrun  output  1  sticky: a byte arrived while rx_full=1.

Interface (already decided):
- One clock, clk. Reset rst is synchronous and active-low.
- All state is updated only on posedge clk. When rst=0 at an edge, all state is reset.

Behaviour:
- Reset values:
  - rx_data=0, rx_full=0, img_recv=0, img_mode=0, frame_err=0, overrun=0.
  - FSM=IDLE. Marker tracker cleared. Synchroniser flops=1.
- rx passes through a 2-flop synchroniser (rxs). Edge detection uses rxs and its previous value.
- FSM:
  - IDLE:
    - On a falling edge of rxs: load timer=BIT_CYC/2, go to START.
  - START:
    - When the timer expires, sample rxs.
    - If rxs=1, it is a false start: go to IDLE, no output.
    - If rxs=0, load timer=BIT_CYC, set bit index=0, go to DATA.
  - DATA:
    - On each timer expiry, shift rxs into bit index (LSB first) and reload timer.
    - After bit 7, go to STOP.
  - STOP:
    - On timer expiry, sample rxs.
    - If rxs=1, the byte is valid. Go to IDLE in the same cycle, so back-to-back frames are accepted.
    - If rxs=0, pulse frame_err and discard the byte; rx_data and rx_full are unchanged. Go to IDLE; a new start is only recognised after rxs returns high.
- Byte delivery, on a valid byte:
  - rx_data<=byte and rx_full<=1 in the cycle after the stop-bit sample.
  - Latency from the start-bit falling edge is about 9.5*BIT_CYC+3 cycles.
- Read handshake:
  - rd=1 clears rx_full on the next edge.
  - If rd=1 and byte delivery happen in the same cycle, delivery wins: rx_full=1.
  - Tying rd=rx_full yields one-cycle rx_full pulses.
- overrun:
  - Set when delivery occurs while rx_full=1 and rd=0; the new byte overwrites.
  - Cleared only by reset.
- Marker detection (only while img_mode=0):
  - Track prev_is_55, set by a valid byte 0x55.
  - A valid 0xAA with prev_is_55=1 pulses img_recv and sets img_mode=1 on the same edge.
  - That 0xAA is not delivered: rx_full and rx_data are untouched. The preceding 0x55 was already delivered.
  - Any other valid byte, or a frame_err, clears prev_is_55.
  - The sequence 0x55 0x55 0xAA also triggers.
- Image mode:
  - All valid bytes, including 0x55 and 0xAA, are delivered normally. No marker detection.
  - end_img_recv=1 clears img_mode and prev_is_55 on the next edge.
  - end_img_recv while img_mode=0 has no effect.
  - If end_img_recv coincides with marker completion, marker completion wins: img_mode=1.
- Reset mid-frame aborts the frame silently. A partially received line frame after reset re-synchronises on the next falling edge seen from IDLE.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined:
  - Every sample point (START check, data bits, stop bit) uses a 2-of-3 majority of rxs at timer expiry -1, 0 and +1.
  - The actual sample is taken one cycle later.
  - Delivery latency grows by 1 cycle.
- Undefined:
  - A single rxs sample at timer expiry. Identical to the base behaviour above.

Decomposition:
- Shared package (uart_pkg): typedef enum logic [1:0] uart_rx_state_t {IDLE, START, DATA, STOP}; constants IMG_MAGIC0=8'h55, IMG_MAGIC1=8'hAA.
- One natural sub-module: uart_rx_core (synchroniser, timer, FSM, outputs byte plus valid/frame_err pulses).
- The top handles the rx_full/overrun handshake and the marker/img_mode logic.

Test Plan (CLOCK_HZ=27e6, BAUD=115200, so BIT_CYC=234):
- Send 0x41 with rd tied to rx_full -> one rx_full pulse, rx_data=0x41, about 2226 cycles after the start edge; no frame_err, img_mode=0.
- Send a 50-cycle low glitch on rx -> false start rejected; no rx_full, no frame_err.
- Send 0x55,0xAA,0x55,0xAA,0x12, then pulse end_img_recv, then 0x55,0xAA:
  - rx_full pulses for 0x55, 0x55, 0xAA, 0x12.
  - img_recv pulses once after the first 0xAA; img_mode drops after end_img_recv.
  - The second marker pulses img_recv again, and its 0xAA is not delivered.
- Send 0x55,0x00,0xAA -> no img_recv; all three bytes delivered.
- Send a frame with stop bit=0 -> frame_err pulse; rx_full stays 0; the next good byte 0x7E is received correctly.
- With rd held 0, send 0x01 then 0x02 -> rx_data=0x02, overrun=1 sticky until rst=0; assert rst=0 mid-frame -> all outputs return to reset values.
